// File: rtl/alu_stream.sv
// Registered streaming ALU with valid/ready handshakes on operand and result sides.
// Define ALU_STREAM_MUL_EN to build the iterative shift-add multiplier for opcode 0010.
module alu_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       s,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             illegal_op
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_NEG = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_XOR = 4'b1001;
   localparam logic [3:0] OP_OR  = 4'b1010;
   localparam logic [3:0] OP_NOT = 4'b1011;
   localparam logic [3:0] OP_ROR = 4'b1100;
   localparam logic [3:0] OP_ROL = 4'b1101;
   localparam logic [3:0] OP_SHR = 4'b1110;
   localparam logic [3:0] OP_SHL = 4'b1111;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             accept, idle, load;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] res, ld_lo;
   logic             res_c, res_v, res_ill;
   logic             ld_c, ld_v, ld_ill;

   assign in_ready = idle && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} - {1'b0, B};

   // Single-cycle datapath; MUL falls to the illegal default here and is
   // picked up by the multiplier when it is compiled in.
   always_comb begin
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_ill = 1'b0;
      case (s)
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_NEG: begin
            res   = ~B + ONE;
            res_c = |B;
            res_v = (B == MIN_NEG);
         end
         OP_AND: res = A & B;
         OP_XOR: res = A ^ B;
         OP_OR:  res = A | B;
         OP_NOT: res = ~B;
         OP_ROR: begin res = {A[0], A[WIDTH-1:1]};       res_c = A[0];       end
         OP_ROL: begin res = {A[WIDTH-2:0], A[WIDTH-1]}; res_c = A[WIDTH-1]; end
         OP_SHR: begin res = {1'b0, A[WIDTH-1:1]};       res_c = A[0];       end
         OP_SHL: begin res = {A[WIDTH-2:0], 1'b0};       res_c = A[WIDTH-1]; end
         default: res_ill = 1'b1;
      endcase
   end

`ifdef ALU_STREAM_MUL_EN
   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod, prod_nxt;
   logic [WIDTH:0]     upper_sum;
   logic [CNT_W-1:0]   cnt;
   logic               mul_start, mul_done;

   assign mul_start = accept && (s == OP_MUL);
   assign mul_done  = (state == MUL) && (cnt == CNT_W'(WIDTH - 1));
   assign idle      = (state == IDLE);

   // Product register starts as {0, multiplier}; each step adds the
   // multiplicand into the upper half on a set LSB, then shifts right.
   assign upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
   assign prod_nxt  = {upper_sum, prod[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mul_start) state_nxt = MUL;
         MUL:     if (mul_done)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand <= '0;
         prod  <= '0;
         cnt   <= '0;
      end else if (mul_start) begin
         mcand <= A;
         prod  <= {{WIDTH{1'b0}}, B};
         cnt   <= '0;
      end else if (state == MUL) begin
         prod  <= prod_nxt;
         cnt   <= cnt + CNT_W'(1);
      end
   end

   assign load   = (accept && !mul_start) || mul_done;
   assign ld_lo  = mul_done ? prod_nxt[WIDTH-1:0] : res;
   assign ld_c   = mul_done ? |prod_nxt[2*WIDTH-1:WIDTH] : res_c;
   assign ld_v   = mul_done ? 1'b0 : res_v;
   assign ld_ill = mul_done ? 1'b0 : res_ill;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  alu_out_hi <= '0;
      else if (load) alu_out_hi <= mul_done ? prod_nxt[2*WIDTH-1:WIDTH] : '0;
   end
`else
   assign idle       = 1'b1;
   assign load       = accept;
   assign ld_lo      = res;
   assign ld_c       = res_c;
   assign ld_v       = res_v;
   assign ld_ill     = res_ill;
   assign alu_out_hi = '0;
`endif

   // Output register holds while the sink stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         alu_out    <= '0;
         flag_z     <= 1'b0;
         flag_n     <= 1'b0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
         illegal_op <= 1'b0;
      end else if (load) begin
         out_valid  <= 1'b1;
         alu_out    <= ld_lo;
         flag_z     <= (ld_lo == '0);
         flag_n     <= ld_lo[WIDTH-1];
         flag_c     <= ld_c;
         flag_v     <= ld_v;
         illegal_op <= ld_ill;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_stream.sv
// Self-checking bench for alu_stream: directed cases plus random ops scored
// against an arithmetic reference model.
module tb_alu_stream;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   op_s;
   logic [W-1:0] op_a, op_b, alu_out, alu_out_hi;
   logic         flag_z, flag_n, flag_c, flag_v, illegal_op;

   int n_chk = 0;
   int n_err = 0;

   alu_stream #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .s(op_s), .A(op_a), .B(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .alu_out(alu_out), .alu_out_hi(alu_out_hi), .flag_z(flag_z), .flag_n(flag_n),
      .flag_c(flag_c), .flag_v(flag_v), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      bit z, n, c, v, ill;
      int edges;
   } exp_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic with signed reinterpretation for V.
   function automatic exp_t ref_op(input int op, input int a, input int b);
      exp_t e;
      int mod  = 1 << W;
      int half = 1 << (W - 1);
      int r = 0;
      int sa, sb, ss;
      e.hi = '0; e.c = 0; e.v = 0; e.ill = 0; e.edges = 0;
      sa = (a >= half) ? a - mod : a;
      sb = (b >= half) ? b - mod : b;
      case (op)
         0: begin r = a + b; e.c = (r >= mod); ss = sa + sb; e.v = (ss >= half) || (ss < -half); end
         1: begin r = a - b; e.c = (a < b);    ss = sa - sb; e.v = (ss >= half) || (ss < -half); end
`ifdef ALU_STREAM_MUL_EN
         2: begin r = a * b; e.hi = W'(r / mod); e.c = ((r / mod) != 0); e.edges = W; end
`endif
         3: begin r = -b; e.c = (b != 0); e.v = (b == half); end
         8: r = a & b;
         9: r = a ^ b;
         10: r = a | b;
         11: r = ~b;
         12: begin r = (a >> 1) | ((a & 1) << (W - 1)); e.c = (a & 1) != 0; end
         13: begin r = (a << 1) | (a >> (W - 1));       e.c = ((a >> (W - 1)) & 1) != 0; end
         14: begin r = a >> 1;                          e.c = (a & 1) != 0; end
         15: begin r = a << 1;                          e.c = ((a >> (W - 1)) & 1) != 0; end
         default: e.ill = 1;
      endcase
      e.lo = W'(r & (mod - 1));
      e.z  = (e.lo == 0);
      e.n  = e.lo[W-1];
      return e;
   endfunction

   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 0;
      bit rdy;
      op_s = op; op_a = a; op_b = b; in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1 rdy = in_ready;
         @(posedge clk); #1;
         ok = rdy;
      end
      in_valid = 1'b0;
      chk("accept", ok, 1);
   endtask

   task automatic collect(input string tag, input exp_t e);
      int edges = 0;
      bit busy_rdy = 0;
      while (!out_valid && edges < 40) begin
         if (in_ready) busy_rdy = 1;
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, " valid"}, out_valid, 1);
      chk({tag, " latency"}, edges, e.edges);
      chk({tag, " ready_busy"}, busy_rdy, 0);
      chk({tag, " lo"}, alu_out, e.lo);
      chk({tag, " hi"}, alu_out_hi, e.hi);
      chk({tag, " zncv"}, {flag_z, flag_n, flag_c, flag_v}, {e.z, e.n, e.c, e.v});
      chk({tag, " ill"}, illegal_op, e.ill);
   endtask

   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e = ref_op(int'(op), int'(a), int'(b));
      send(op, a, b);
      collect($sformatf("op%0h %0h,%0h", op, a, b), e);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e1, e2, e3, e;
      bit stray;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op_s = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset outs", {out_valid, alu_out, alu_out_hi, flag_z, flag_n, flag_c, flag_v, illegal_op}, 0);
      @(negedge clk) reset_n = 1'b1;
      #1 chk("post-reset in_ready", in_ready, 1);

      // ADD / SUB flags
      do_op(4'h0, 8'h7F, 8'h01);
      chk("add7f lo", alu_out, 8'h80);
      chk("add7f ncv", {flag_n, flag_c, flag_v}, 3'b101);
      do_op(4'h0, 8'hFF, 8'h01);
      chk("addff zc", {alu_out, flag_z, flag_c}, {8'h00, 2'b11});
      do_op(4'h1, 8'h03, 8'h05);
      chk("sub lo", alu_out, 8'hFE);
      chk("sub cn", {flag_c, flag_n}, 2'b11);

      // Shift / rotate / NEG
      do_op(4'hC, 8'h81, 8'h00);
      chk("ror", {alu_out, flag_c}, {8'hC0, 1'b1});
      do_op(4'hF, 8'h81, 8'h00);
      chk("shl", {alu_out, flag_c}, {8'h02, 1'b1});
      do_op(4'h3, 8'h00, 8'h80);
      chk("neg", {alu_out, flag_v, flag_c}, {8'h80, 2'b11});

      // MUL (or illegal when compiled out)
      do_op(4'h2, 8'hFF, 8'hFF);
`ifdef ALU_STREAM_MUL_EN
      chk("mul prod", {alu_out_hi, alu_out, flag_c}, {8'hFE, 8'h01, 1'b1});
`else
      chk("mul illegal", {alu_out, illegal_op}, {8'h00, 1'b1});
`endif

      // Illegal opcode, then a legal op clears it
      do_op(4'h5, 8'h12, 8'h34);
      chk("illegal", {alu_out, flag_z, illegal_op}, {8'h00, 2'b11});
      do_op(4'h0, 8'h01, 8'h01);
      chk("illegal clear", illegal_op, 0);

      // Back-pressure: three back-to-back ADDs against a stalled sink
      drain();
      out_ready = 1'b0;
      e1 = ref_op(0, 10, 20);
      e2 = ref_op(0, 'h55, 'h11);
      e3 = ref_op(0, 'hF0, 'h20);
      send(4'h0, 8'd10, 8'd20);
      op_s = 4'h0; op_a = 8'h55; op_b = 8'h11; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp hold%0d", k), {out_valid, alu_out, in_ready}, {1'b1, e1.lo, 1'b0});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1 chk("bp ready", in_ready, 1);
      @(posedge clk); #1;
      chk("bp r2", {out_valid, alu_out}, {1'b1, e2.lo});
      op_a = 8'hF0; op_b = 8'h20;
      @(posedge clk); #1;
      chk("bp r3", {out_valid, alu_out, flag_c}, {1'b1, e3.lo, e3.c});
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp empty", out_valid, 0);

      // Reset in the middle of a multiply
      send(4'h2, 8'hFF, 8'hFF);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
      #1 chk("midmul reset", {out_valid, alu_out, alu_out_hi, flag_z, flag_n, flag_c, flag_v, illegal_op}, 0);
      @(negedge clk) reset_n = 1'b1;
      #1 chk("midmul in_ready", in_ready, 1);
      stray = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) stray = 1;
      end
      chk("midmul stray", stray, 0);

      // Random ops with occasional sink stalls
      for (int i = 0; i < 150; i++) begin
         logic [3:0]   rop;
         logic [W-1:0] ra, rb;
         int stall;
         rop = 4'($urandom_range(0, 15));
         ra  = W'($urandom);
         rb  = W'($urandom);
         e = ref_op(int'(rop), int'(ra), int'(rb));
         send(rop, ra, rb);
         collect($sformatf("rnd%0d op%0h %0h,%0h", i, rop, ra, rb), e);
         stall = $urandom_range(0, 3);
         if (stall == 3) begin
            out_ready = 1'b0;
            repeat (2) begin
               @(posedge clk); #1;
               chk("rnd hold", {out_valid, alu_out, alu_out_hi}, {1'b1, e.lo, e.hi});
            end
            out_ready = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_stream.md
Name: alu_stream

Overview:
- Parametrised, registered ALU with valid/ready handshakes on both the operand and result sides.
- Keeps the established 4-bit opcode map and adds status flags, an illegal-opcode indication and an iterative multi-cycle multiply.
- Sits between an operand source (register file or sequencer) and a result sink that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts operands this cycle.
- s  in  4  opcode.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  sink accepts result.
- alu_out  out  WIDTH  result (low half for MUL).
- alu_out_hi  out  WIDTH  high half of MUL product; 0 for all other ops.
- flag_z  out  1  alu_out == 0.
- flag_n  out  1  alu_out[WIDTH-1].
- flag_c  out  1  carry/borrow/shifted-out bit.
- flag_v  out  1  signed overflow.
- illegal_op  out  1  opcode not implemented.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; out_valid, alu_out, alu_out_hi, all flags, illegal_op = 0; mult counter = 0. Reset mid-multiply aborts the operation; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Acceptance = in_valid && in_ready at a rising edge.
- Output register: loaded on completion; holds all outputs stable while out_valid && !out_ready; out_valid clears on handshake unless a new result loads the same edge.
- Single-cycle ops: out_valid rises at the edge of acceptance (latency 1). Back-to-back throughput is 1 op/cycle when out_ready=1.
- Opcode map and flag rules:
  - 0000 ADD: A+B. C=carry out. V=signed overflow.
  - 0001 SUB: A-B. C=borrow (A<B unsigned). V=signed overflow.
  - 0011 NEG: ~B+1. C=(B!=0). V=(B==100..0).
  - 1000 AND, 1001 XOR, 1010 OR, 1011 NOT B: C=0, V=0.
  - 1100 ROR: {A[0],A[W-1:1]}, C=A[0]. 1101 ROL: {A[W-2:0],A[W-1]}, C=A[W-1].
  - 1110 SHR logical: C=A[0]. 1111 SHL: C=A[W-1]. V=0 for all shifts/rotates.
  - 0010 MUL: unsigned A*B, 2*WIDTH product; see below.
  - 0100-0111 (and 0010 when multiply is compiled out): result 0, illegal_op=1, flag_z=1, other flags 0, latency 1.
- Z and N are always derived from alu_out. illegal_op=0 for legal ops.
- MUL FSM: IDLE -> MUL on acceptance.
  - MUL performs shift-add, one multiplier bit per cycle, WIDTH cycles.
  - On the WIDTH-th edge after acceptance: {alu_out_hi, alu_out} = product, out_valid=1, state -> IDLE.
  - C = (alu_out_hi != 0); V=0.
  - in_ready=0 throughout MUL. A/B/s changes during MUL are ignored (operands latched at acceptance).
- Widths: all arithmetic is computed at WIDTH+1 bits for carry; results are truncated to WIDTH.

Optional Feature:
- Macro ALU_STREAM_MUL_EN.
- Defined: MUL opcode 0010 is implemented as above, and the FSM/counter/accumulator are present.
- Undefined: no multiply datapath or MUL state; 0010 is treated as an illegal opcode (latency 1, illegal_op=1); alu_out_hi is tied to 0.

Test Plan:
- Reset: drive reset_n=0 mid-MUL (WIDTH=8, A=8'hFF, B=8'hFF, 3 cycles in) -> all outputs 0 immediately; after release in_ready=1 and no stray out_valid.
- ADD/SUB flags: ADD 8'h7F+8'h01 -> 8'h80, N=1, V=1, C=0; ADD 8'hFF+8'h01 -> 8'h00, Z=1, C=1; SUB 8'h03-8'h05 -> 8'hFE, C=1, N=1.
- Shift/rotate/NEG: ROR 8'h81 -> 8'hC0, C=1; SHL 8'h81 -> 8'h02, C=1; NEG B=8'h80 -> 8'h80, V=1, C=1.
- Back-pressure: 3 back-to-back ADDs with out_ready=0 for 4 cycles -> first result held stable, in_ready=0 after the first acceptance; results delivered in order once out_ready=1.
- MUL (macro defined): 8'hFF*8'hFF -> out_valid exactly 8 edges after acceptance, alu_out=8'h01, alu_out_hi=8'hFE, C=1, in_ready=0 during MUL. Macro undefined: same stimulus -> illegal_op=1, alu_out=0, latency 1.
- Illegal opcode 0101 with A=8'h12, B=8'h34 -> alu_out=0, Z=1, illegal_op=1; the next legal op clears illegal_op.
